// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W_DEF = 5;
  localparam int unsigned CNT_W     = 32;

  // Memory-sequencing FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } mem_state_e;

  // Execute-stage operand select encodings
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Forwarding selects produced by the forwarding unit
  typedef struct packed {
    logic [1:0] fwd_a_e;
    logic [1:0] fwd_b_e;
    logic       fwd_a_d;
    logic       fwd_b_d;
  } fwd_sel_t;

  // Saturating increment for the event counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic en);
    if (en && (val != '1)) begin
      return val + CNT_W'(1);
    end
    return val;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) ();

  logic [REG_W-1:0] RsD;
  logic [REG_W-1:0] RtD;
  logic [REG_W-1:0] RsE;
  logic [REG_W-1:0] RtE;
  logic [REG_W-1:0] WriteRegE;
  logic [REG_W-1:0] WriteRegM;
  logic [REG_W-1:0] WriteRegW;
  logic             RegWriteE;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             MemtoRegE;
  logic             MemtoRegM;
  logic             BranchD;
  logic             PCSrcD;
  logic             MemAccessM;
  logic             MemReadyM;

  logic             MemReqM;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             ForwardAD;
  logic             ForwardBD;
  logic             MemErr;

  // Pipeline side
  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    output BranchD, PCSrcD, MemAccessM, MemReadyM,
    input  MemReqM, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemErr
  );

  // Hazard controller side
  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    input  BranchD, PCSrcD, MemAccessM, MemReadyM,
    output MemReqM, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemErr
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Combinational operand-forwarding selects for the E and D stages.
module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] write_reg_m,
  input  logic [REG_W-1:0] write_reg_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output fwd_sel_t         fwd_c
);

  // r0 is hardwired, so it never matches as a producer
  function automatic logic reg_hit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return (src != '0) && (dst == src);
  endfunction

  // M-stage result takes priority over the older W-stage result
  always_comb begin
    fwd_c = '{fwd_a_e: FWD_RF, fwd_b_e: FWD_RF, fwd_a_d: 1'b0, fwd_b_d: 1'b0};

    if (reg_write_m && reg_hit(write_reg_m, rs_e)) begin
      fwd_c.fwd_a_e = FWD_M;
    end else if (reg_write_w && reg_hit(write_reg_w, rs_e)) begin
      fwd_c.fwd_a_e = FWD_W;
    end

    if (reg_write_m && reg_hit(write_reg_m, rt_e)) begin
      fwd_c.fwd_b_e = FWD_M;
    end else if (reg_write_w && reg_hit(write_reg_w, rt_e)) begin
      fwd_c.fwd_b_e = FWD_W;
    end

    fwd_c.fwd_a_d = reg_write_m && reg_hit(write_reg_m, rs_d);
    fwd_c.fwd_b_d = reg_write_m && reg_hit(write_reg_m, rt_d);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding,
// load-use / branch stalls, flushes and variable-latency data-memory sequencing.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall-event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W       = REG_W_DEF,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned MEM_TIMEOUT = 200
) (
  input  logic             clock,
  input  logic             reset,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] LuStallCnt,
  output logic [CNT_W-1:0] BrStallCnt,
  output logic [CNT_W-1:0] MemStallCnt,
`endif
  hazard_ctrl_if.slave     bus
);

  mem_state_e       state_q;
  mem_state_e       state_d;
  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  logic     memstall_c;
  logic     mem_req_c;
  logic     mem_err_c;
  logic     lwstall_c;
  logic     brstall_c;
  logic     pipe_hold_c;
  logic     stall_f_c;
  logic     stall_d_c;
  logic     stall_e_c;
  logic     stall_m_c;
  logic     flush_d_c;
  logic     flush_e_c;
  logic     flush_w_c;
  fwd_sel_t fwd_c;

  // r0 is hardwired, so it never creates a hazard
  function automatic logic reg_hit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return (src != '0) && (dst == src);
  endfunction

  hazard_fwd_unit #(
    .REG_W (REG_W)
  ) u_fwd (
    .rs_d        (bus.RsD),
    .rt_d        (bus.RtD),
    .rs_e        (bus.RsE),
    .rt_e        (bus.RtE),
    .write_reg_m (bus.WriteRegM),
    .write_reg_w (bus.WriteRegW),
    .reg_write_m (bus.RegWriteM),
    .reg_write_w (bus.RegWriteW),
    .fwd_c       (fwd_c)
  );

  // Load in E feeding a D-stage source, and branch compares waiting on E/M results
  always_comb begin
    lwstall_c = bus.MemtoRegE &&
                (reg_hit(bus.WriteRegE, bus.RsD) || reg_hit(bus.WriteRegE, bus.RtD));
    brstall_c = bus.BranchD &&
                ((bus.RegWriteE &&
                  (reg_hit(bus.WriteRegE, bus.RsD) || reg_hit(bus.WriteRegE, bus.RtD))) ||
                 (bus.MemtoRegM &&
                  (reg_hit(bus.WriteRegM, bus.RsD) || reg_hit(bus.WriteRegM, bus.RtD))));
    pipe_hold_c = lwstall_c || brstall_c;
  end

  // FSM state and wait-counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a miss enters WAIT, ready wins over timeout, ERR is terminal
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.MemAccessM && !bus.MemReadyM) begin
          state_d = ST_WAIT;
          cnt_d   = TMO_W'(1);
        end
      end
      ST_WAIT: begin
        if (bus.MemReadyM) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_W'(MEM_TIMEOUT)) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: memory request, memory stall and sticky error
  always_comb begin
    mem_req_c  = 1'b0;
    memstall_c = 1'b0;
    mem_err_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_req_c  = bus.MemAccessM;
        memstall_c = bus.MemAccessM && !bus.MemReadyM;
      end
      ST_WAIT: begin
        mem_req_c  = 1'b1;
        memstall_c = !bus.MemReadyM;
      end
      ST_ERR: begin
        memstall_c = 1'b1;
        mem_err_c  = 1'b1;
      end
      default: begin
        mem_req_c = 1'b0;
      end
    endcase
  end

  // Memory stall freezes F..M and bubbles W without discarding anything upstream
  always_comb begin
    stall_f_c = 1'b0;
    stall_d_c = 1'b0;
    stall_e_c = 1'b0;
    stall_m_c = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    flush_w_c = 1'b0;
    if (memstall_c) begin
      stall_f_c = 1'b1;
      stall_d_c = 1'b1;
      stall_e_c = 1'b1;
      stall_m_c = 1'b1;
      flush_w_c = 1'b1;
    end else begin
      stall_f_c = pipe_hold_c;
      stall_d_c = pipe_hold_c;
      flush_e_c = pipe_hold_c;
      flush_d_c = bus.PCSrcD && !pipe_hold_c;
    end
  end

  assign bus.MemReqM   = mem_req_c;
  assign bus.MemErr    = mem_err_c;
  assign bus.StallF    = stall_f_c;
  assign bus.StallD    = stall_d_c;
  assign bus.StallE    = stall_e_c;
  assign bus.StallM    = stall_m_c;
  assign bus.FlushD    = flush_d_c;
  assign bus.FlushE    = flush_e_c;
  assign bus.FlushW    = flush_w_c;
  assign bus.ForwardAE = fwd_c.fwd_a_e;
  assign bus.ForwardBE = fwd_c.fwd_b_e;
  assign bus.ForwardAD = fwd_c.fwd_a_d;
  assign bus.ForwardBD = fwd_c.fwd_b_d;

`ifdef HAZARD_PERF_CNT_EN
  // Stall-event counters; hazard stalls count only when they actually gate the pipe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      LuStallCnt  <= '0;
      BrStallCnt  <= '0;
      MemStallCnt <= '0;
    end else begin
      LuStallCnt  <= sat_inc(LuStallCnt, lwstall_c && !memstall_c);
      BrStallCnt  <= sat_inc(BrStallCnt, brstall_c && !memstall_c);
      MemStallCnt <= sat_inc(MemStallCnt, memstall_c);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (timeout shortened to 4 cycles).
module tb_hazard_ctrl;

  localparam int unsigned RW  = 5;
  localparam int unsigned TW  = 8;
  localparam int unsigned TMO = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;

  // Model state: cycles the current access has waited, and terminal failure
  int m_wait = 0;
  bit m_dead = 1'b0;

  hazard_ctrl_if #(.REG_W(RW)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt;
  logic [31:0] br_cnt;
  logic [31:0] mem_cnt;
  int m_lu  = 0;
  int m_br  = 0;
  int m_mem = 0;
`endif

  hazard_ctrl #(
    .REG_W       (RW),
    .TMO_W       (TW),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
`ifdef HAZARD_PERF_CNT_EN
    .LuStallCnt  (lu_cnt),
    .BrStallCnt  (br_cnt),
    .MemStallCnt (mem_cnt),
`endif
    .bus         (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [RW-1:0] dst, input logic [RW-1:0] src);
    return (src != 0) && (dst == src);
  endfunction

  function automatic bit lu_now();
    return bus.MemtoRegE && (hit(bus.WriteRegE, bus.RsD) || hit(bus.WriteRegE, bus.RtD));
  endfunction

  function automatic bit br_now();
    bit from_e;
    bit from_m;
    from_e = bus.RegWriteE && (hit(bus.WriteRegE, bus.RsD) || hit(bus.WriteRegE, bus.RtD));
    from_m = bus.MemtoRegM && (hit(bus.WriteRegM, bus.RsD) || hit(bus.WriteRegM, bus.RtD));
    return bus.BranchD && (from_e || from_m);
  endfunction

  function automatic bit busy_now();
    return m_dead || (((m_wait > 0) || bus.MemAccessM) && !bus.MemReadyM);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [RW-1:0] src);
    if (bus.RegWriteM && hit(bus.WriteRegM, src)) return 2'b10;
    if (bus.RegWriteW && hit(bus.WriteRegW, src)) return 2'b01;
    return 2'b00;
  endfunction

  // Expected output vector from the rules and the model's memory state
  function automatic logic [14:0] model_out();
    bit busy;
    bit hold;
    bit req;
    busy = busy_now();
    hold = !busy && (lu_now() || br_now());
    req  = !m_dead && ((m_wait > 0) || bus.MemAccessM);
    return {req, busy || hold, busy || hold, busy, busy,
            !busy && !hold && bus.PCSrcD, hold, busy,
            fwd_e(bus.RsE), fwd_e(bus.RtE),
            bus.RegWriteM && hit(bus.WriteRegM, bus.RsD),
            bus.RegWriteM && hit(bus.WriteRegM, bus.RtD),
            m_dead};
  endfunction

  function automatic logic [14:0] dut_out();
    return {bus.MemReqM, bus.StallF, bus.StallD, bus.StallE, bus.StallM,
            bus.FlushD, bus.FlushE, bus.FlushW, bus.ForwardAE, bus.ForwardBE,
            bus.ForwardAD, bus.ForwardBD, bus.MemErr};
  endfunction

  // Model update on each active edge
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_wait = 0;
      m_dead = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
      m_lu  = 0;
      m_br  = 0;
      m_mem = 0;
`endif
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (busy_now()) m_mem++;
      else begin
        if (lu_now()) m_lu++;
        if (br_now()) m_br++;
      end
`endif
      if (!m_dead) begin
        if (((m_wait > 0) || bus.MemAccessM) && !bus.MemReadyM) begin
          if (m_wait == int'(TMO)) m_dead = 1'b1;
          else m_wait++;
        end else begin
          m_wait = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cycle_outputs", 32'(dut_out()), 32'(model_out()));
`ifdef HAZARD_PERF_CNT_EN
      chk("lu_cnt", lu_cnt, 32'(m_lu));
      chk("br_cnt", br_cnt, 32'(m_br));
      chk("mem_cnt", mem_cnt, 32'(m_mem));
`endif
    end
  end

  task automatic clr();
    bus.RsD = '0; bus.RtD = '0; bus.RsE = '0; bus.RtE = '0;
    bus.WriteRegE = '0; bus.WriteRegM = '0; bus.WriteRegW = '0;
    bus.RegWriteE = 1'b0; bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
    bus.MemtoRegE = 1'b0; bus.MemtoRegM = 1'b0;
    bus.BranchD = 1'b0; bus.PCSrcD = 1'b0;
    bus.MemAccessM = 1'b0; bus.MemReadyM = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clr();
    #2;
    cmp_en = 1'b1;
    chk("reset_outputs", 32'(dut_out()), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Forwarding priority and r0
    step(); bus.RegWriteM = 1'b1; bus.WriteRegM = 5'd8; bus.RsE = 5'd8;
    bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd8;
    #1 chk("fwd_ae_from_m", 32'(bus.ForwardAE), 32'h2);
    step(); bus.RegWriteM = 1'b0;
    #1 chk("fwd_ae_from_w", 32'(bus.ForwardAE), 32'h1);
    step(); bus.RegWriteM = 1'b1; bus.WriteRegM = 5'd0; bus.WriteRegW = 5'd0; bus.RsE = 5'd0;
    #1 chk("fwd_ae_r0", 32'(bus.ForwardAE), 32'h0);
    step(); clr(); bus.RtE = 5'd3; bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd3;
    bus.RegWriteM = 1'b1; bus.WriteRegM = 5'd5;
    #1 chk("fwd_be_from_w", 32'(bus.ForwardBE), 32'h1);

    // Load-use: one stall cycle, then load in M forwards to D
    step(); clr(); bus.MemtoRegE = 1'b1; bus.RegWriteE = 1'b1; bus.WriteRegE = 5'd9; bus.RtD = 5'd9;
    #1 chk("lu_stall", 32'({bus.StallF, bus.StallD, bus.FlushE, bus.StallE}), 32'b1110);
    step(); bus.MemtoRegE = 1'b0; bus.RegWriteE = 1'b0; bus.WriteRegE = 5'd0;
    bus.MemtoRegM = 1'b1; bus.RegWriteM = 1'b1; bus.WriteRegM = 5'd9;
    #1 chk("lu_release", 32'({bus.StallF, bus.StallD, bus.FlushE}), 32'b000);
    chk("lu_fwd_bd", 32'(bus.ForwardBD), 32'h1);
    step(); clr(); bus.MemtoRegE = 1'b1;
    #1 chk("lu_r0", 32'(bus.StallD), 32'h0);

    // Branch compare: forward from M, flush on taken, stall on E / load in M
    step(); clr(); bus.BranchD = 1'b1; bus.RsD = 5'd4; bus.RegWriteM = 1'b1; bus.WriteRegM = 5'd4;
    #1 chk("br_fwd_ad", 32'({bus.ForwardAD, bus.StallD}), 32'b10);
    step(); bus.PCSrcD = 1'b1;
    #1 chk("br_flush_d", 32'(bus.FlushD), 32'h1);
    step(); bus.RegWriteE = 1'b1; bus.WriteRegE = 5'd4;
    #1 chk("br_stall_e", 32'({bus.StallF, bus.StallD, bus.FlushE, bus.FlushD}), 32'b1110);
    step(); bus.RegWriteE = 1'b0; bus.WriteRegE = 5'd0; bus.MemtoRegM = 1'b1;
    #1 chk("br_stall_ld_m", 32'({bus.StallD, bus.FlushE, bus.FlushD}), 32'b110);

    // Memory wait: 3 miss cycles then ready; {Req,SF,SD,SE,SM,FW,FE,FD}
    step(); clr(); bus.MemAccessM = 1'b1;
    #1 chk("mw_miss1", 32'({bus.MemReqM, bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                            bus.FlushW, bus.FlushE, bus.FlushD}), 32'b11111100);
    step(); bus.MemtoRegE = 1'b1; bus.WriteRegE = 5'd9; bus.RtD = 5'd9; bus.PCSrcD = 1'b1;
    #1 chk("mw_miss2_lu", 32'({bus.MemReqM, bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                               bus.FlushW, bus.FlushE, bus.FlushD}), 32'b11111100);
    step(); bus.MemtoRegE = 1'b0; bus.WriteRegE = 5'd0; bus.RtD = 5'd0; bus.PCSrcD = 1'b0;
    #1 chk("mw_miss3", 32'({bus.MemReqM, bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                            bus.FlushW, bus.FlushE, bus.FlushD}), 32'b11111100);
    step(); bus.MemReadyM = 1'b1;
    #1 chk("mw_ready", 32'({bus.MemReqM, bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                            bus.FlushW, bus.FlushE, bus.FlushD}), 32'b10000000);
    step(); clr();
    #1 chk("mw_idle", 32'(dut_out()), 32'd0);

    // Timeout: never ready; ERR after 4 cycles in WAIT
    step(); bus.MemAccessM = 1'b1;
    repeat (4) step();
    #1 chk("to_last_wait", 32'({bus.MemErr, bus.MemReqM}), 32'b01);
    step();
    #1 chk("to_err", 32'({bus.MemErr, bus.MemReqM, bus.StallF, bus.StallD, bus.StallE,
                          bus.StallM, bus.FlushW}), 32'b1011111);
    step(); bus.MemReadyM = 1'b1;
    #1 chk("to_ready_ignored", 32'({bus.MemErr, bus.MemReqM, bus.StallM}), 32'b101);
    step(); bus.MemAccessM = 1'b0;
    #1 chk("to_sticky", 32'(bus.MemErr), 32'h1);

    // Reset clears ERR
    step(); reset = 1'b0; clr();
    #1 chk("rst_from_err", 32'(dut_out()), 32'd0);
    @(negedge clock); reset = 1'b1;

    // Reset mid-WAIT, then a fresh access
    step(); bus.MemAccessM = 1'b1;
    step();
    step();
    #1 chk("rw_waiting", 32'({bus.MemReqM, bus.StallM}), 32'b11);
    reset = 1'b0; clr();
    #1 chk("rw_reset", 32'(dut_out()), 32'd0);
    @(negedge clock); reset = 1'b1;
    step(); bus.MemAccessM = 1'b1; bus.MemReadyM = 1'b1;
    #1 chk("fresh_hit", 32'({bus.MemReqM, bus.StallF, bus.StallM, bus.FlushW}), 32'b1000);
    step(); bus.MemReadyM = 1'b0;
    #1 chk("fresh_miss", 32'({bus.MemReqM, bus.StallM}), 32'b11);
    step(); bus.MemReadyM = 1'b1;
    #1 chk("fresh_done", 32'({bus.MemReqM, bus.StallM, bus.MemErr}), 32'b100);
    step(); clr();
    repeat (2) step();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
